flit_requester: RTL and testbench
=================================

FLIT_REQUESTER -- requirements
Module: flit_requester

Interface
REQ-001 SHALL have parameter DATA_W, default 32: flit payload width.
REQ-002 SHALL have parameter LEN_W, default 12: packet length field width, in flits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid, input, 1: upstream beat valid.
REQ-006 SHALL have port s_ready, output, 1: upstream beat accepted when s_valid && s_ready.
REQ-007 SHALL have port s_data, input, DATA_W: upstream payload.
REQ-008 SHALL have port s_last, input, 1: beat is the last of its packet.
REQ-009 SHALL have port s_length, input, LEN_W: packet length in flits, sampled on the first beat only.
REQ-010 SHALL have port grant, input, 1: this port's bit of the arbiter's one-hot grant state.
REQ-011 SHALL have port req, output, 1: request to the arbiter.
REQ-012 SHALL have port flit_id, output, 3: flit type; 3'b000 idle, 3'b001 header, 3'b010 body, 3'b100 tail.
REQ-013 SHALL have port length, output, LEN_W: current packet length, held stable for the whole packet.
REQ-014 SHALL have port flit_data, output, DATA_W: payload of the presented flit.
REQ-015 SHALL have port len_err, output, 1: sticky length-mismatch flag.

Function
REQ-016 SHALL hold one presented flit in an output register, with valid bit hv; req SHALL equal hv.
REQ-017 SHALL transfer a flit in any cycle where req && grant; there is no other transfer condition.
REQ-018 SHALL drive s_ready = !hv || grant, so a refill and a transfer can happen in the same cycle (zero-bubble streaming).
REQ-019 SHALL run an FSM with three states:
- IDLE: no packet open.
- HEAD: header presented.
- BODY: mid-packet.
REQ-020 SHALL set the following on an accepted beat while in IDLE, or at the tail transfer:
- flit_id = 3'b001.
- length = s_length.
- flit count = 1.
- next state = HEAD.
REQ-021 SHALL set flit_id to 3'b100 for a later beat with s_last=1, and 3'b010 otherwise; state = BODY.
REQ-022 SHALL close the packet when a beat with s_last=1 is the first beat: send a header only and return to IDLE after its transfer.
REQ-023 SHALL keep req, flit_id, length and flit_data unchanged when grant falls mid-packet (arbiter timeout), and resume on the next grant without resending the header.
REQ-024 SHALL, after the tail transfer, drop req the next cycle if no beat was accepted; otherwise present the next header (flit_id 3'b001) back-to-back.
REQ-025 SHALL use a LEN_W-bit flit counter that saturates at all-ones and never wraps.
REQ-026 SHALL drive flit_id = 3'b000 whenever hv = 0.

Reset
REQ-027 SHALL, while rst = 0, force these to zero: req, flit_id, length, flit_data, len_err, hv, counter and s_ready; FSM state = IDLE.
REQ-028 SHALL discard any partially sent packet on reset mid-packet; after release, the first accepted beat is treated as a header.
REQ-029 SHALL drive s_ready = 1 on the first clock edge after rst deasserts.

Configuration
REQ-030 SHALL, with FLIT_REQ_LEN_CHECK_EN defined, set len_err = 1 in either case below, held until reset:
- The tail is accepted with counter != length.
- The counter reaches length without s_last.
REQ-031 SHALL, without FLIT_REQ_LEN_CHECK_EN, tie len_err to 0 and synthesise no compare logic.

Structure
REQ-032 SHALL take from the shared NoC package:
- Flit-id constants FLIT_IDLE, FLIT_HEAD, FLIT_BODY, FLIT_TAIL.
- The requester state enum.
- The default LEN_W.
REQ-033 SHALL be a single module with no sub-module; the output register and FSM are local.

Verification
REQ-034 SHALL test a 3-beat packet with s_length = 3 and grant held high:
- Expected flit_id sequence: 001, 010, 100 on consecutive cycles.
- req falls 1 cycle after the tail.
- len_err = 0.
REQ-035 SHALL test grant dropped for 4 cycles after the header of a 5-flit packet:
- req, flit_id = 010 and flit_data are stable for those 4 cycles.
- Expected remaining sequence: 010, 010, 010, 100.
REQ-036 SHALL test two back-to-back packets (length 2, then length 1) with continuous s_valid:
- Expected flit_id sequence: 001, 100, 001.
- No idle cycle; s_ready stays 1.
REQ-037 SHALL test with FLIT_REQ_LEN_CHECK_EN defined, s_length = 4, and s_last on the 3rd beat: len_err rises after the tail and stays 1.
REQ-038 SHALL test rst pulsed low mid-BODY:
- Outputs go to 0 asynchronously.
- After release, the first beat is sent with flit_id = 001.

Source files
------------

// File: rtl/flit_requester_pkg.sv
// Shared NoC definitions for the flit requester: flit-id codes, requester FSM states, default length width.
// Declarations only; no latency or backpressure of its own.
package flit_requester_pkg;

    localparam int LEN_W_DEF = 12;

    localparam logic [2:0] FLIT_IDLE = 3'b000;
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_HEAD = 2'd1,
        REQ_BODY = 2'd2
    } req_state_t;

endpackage

// File: rtl/flit_requester.sv
// Packetises an upstream beat stream into header/body/tail flits for a NoC arbiter; FLIT_REQ_LEN_CHECK_EN adds a sticky length check.
// One-cycle register latency; s_ready = !hv || grant, so a refill and a transfer can share a cycle.
module flit_requester
    import flit_requester_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [LEN_W-1:0]  s_length,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] flit_data,
    output logic              len_err
);

    req_state_t        r_state;
    req_state_t        w_state_nxt;
    logic              r_hv;
    logic              r_last;
    logic              r_en;
    logic [2:0]        r_id;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;

    logic              w_xfer;
    logic              w_acc;
    logic              w_hdr;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [2:0]        w_id_nxt;

    assign w_xfer  = r_hv && grant;
    assign s_ready = r_en && (!r_hv || grant);
    assign w_acc   = s_valid && s_ready;
    // r_last implies the presented flit closes its packet, so any beat accepted now opens a new one
    assign w_hdr   = (r_state == REQ_IDLE) || r_last;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_hdr) begin
            w_cnt_nxt = {{(LEN_W-1){1'b0}}, 1'b1};
        end else if (!(&r_cnt)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_id_nxt = FLIT_BODY;
        if (w_hdr) begin
            w_id_nxt = FLIT_HEAD;
        end else if (s_last) begin
            w_id_nxt = FLIT_TAIL;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = w_hdr ? REQ_HEAD : REQ_BODY;
        end else if (w_xfer && r_last) begin
            w_state_nxt = REQ_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= REQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en   <= 1'b0;
            r_hv   <= 1'b0;
            r_last <= 1'b0;
            r_id   <= FLIT_IDLE;
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_acc) begin
                r_hv   <= 1'b1;
                r_last <= s_last;
                r_id   <= w_id_nxt;
                r_cnt  <= w_cnt_nxt;
                r_data <= s_data;
                if (w_hdr) begin
                    r_len <= s_length;
                end
            end else if (w_xfer) begin
                r_hv   <= 1'b0;
                r_last <= 1'b0;
                r_id   <= FLIT_IDLE;
            end
        end
    end

    assign req       = r_hv;
    assign flit_id   = r_hv ? r_id : FLIT_IDLE;
    assign length    = r_len;
    assign flit_data = r_data;

`ifdef FLIT_REQ_LEN_CHECK_EN
    logic             r_len_err;
    logic [LEN_W-1:0] w_len_ref;
    logic             w_mis;

    // a header carries its own length; later beats compare against the latched one
    assign w_len_ref = w_hdr ? s_length : r_len;
    assign w_mis     = w_acc && (s_last ? (w_cnt_nxt != w_len_ref) : (w_cnt_nxt == w_len_ref));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_err <= 1'b0;
        end else if (w_mis) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err = r_len_err;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_flit_requester.sv
// Directed bench for flit_requester: streaming, grant stalls, back-to-back packets, length check, mid-packet reset.
module tb_flit_requester;

`ifdef FLIT_REQ_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [11:0] s_length = '0;
    logic        grant = 1'b0;
    logic        req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic [31:0] flit_data;
    logic        len_err;

    int n_chk  = 0;
    int n_pass = 0;

    flit_requester dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_length (s_length),
        .grant    (grant),
        .req      (req),
        .flit_id  (flit_id),
        .length   (length),
        .flit_data(flit_data),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic beat(input logic v, input logic [31:0] d, input logic l,
                        input logic [11:0] n, input logic g);
        s_valid  = v;
        s_data   = d;
        s_last   = l;
        s_length = n;
        grant    = g;
    endtask

    // inputs are changed at the falling edge; one call advances through one rising edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flit(input string tag, input logic [2:0] id, input logic [31:0] d);
        chk({tag, ".req"}, {31'd0, req}, 32'd1);
        chk({tag, ".id"}, {29'd0, flit_id}, {29'd0, id});
        chk({tag, ".data"}, flit_data, d);
    endtask

    task automatic idle(input string tag);
        chk({tag, ".req"}, {31'd0, req}, 32'd0);
        chk({tag, ".id"}, {29'd0, flit_id}, 32'd0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.req", {31'd0, req}, 32'd0);
        chk("rst.id", {29'd0, flit_id}, 32'd0);
        chk("rst.len", {20'd0, length}, 32'd0);
        chk("rst.data", flit_data, 32'd0);
        chk("rst.err", {31'd0, len_err}, 32'd0);
        chk("rst.rdy", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.rdy_before_edge", {31'd0, s_ready}, 32'd0);
        cyc();
        chk("rel.rdy_first_edge", {31'd0, s_ready}, 32'd1);

        // 3-beat packet, grant held
        beat(1, 32'hA1, 0, 12'd3, 1);
        cyc();
        flit("p3.h", 3'b001, 32'hA1);
        chk("p3.len", {20'd0, length}, 32'd3);
        beat(1, 32'hA2, 0, 12'd0, 1);
        cyc();
        flit("p3.b", 3'b010, 32'hA2);
        beat(1, 32'hA3, 1, 12'd0, 1);
        cyc();
        flit("p3.t", 3'b100, 32'hA3);
        chk("p3.len_hold", {20'd0, length}, 32'd3);
        beat(0, 32'h0, 0, 12'd0, 1);
        cyc();
        idle("p3.end");
        chk("p3.err", {31'd0, len_err}, 32'd0);

        // 5-flit packet with grant dropped for 4 cycles after the header
        beat(1, 32'hB1, 0, 12'd5, 1);
        cyc();
        flit("p5.h", 3'b001, 32'hB1);
        beat(1, 32'hB2, 0, 12'd0, 1);
        cyc();
        flit("p5.b2", 3'b010, 32'hB2);
        beat(1, 32'hB3, 0, 12'd0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("p5.stall_rdy", {31'd0, s_ready}, 32'd0);
            cyc();
            flit("p5.stall", 3'b010, 32'hB2);
            chk("p5.stall_len", {20'd0, length}, 32'd5);
        end
        grant = 1'b1;
        cyc();
        flit("p5.b3", 3'b010, 32'hB3);
        beat(1, 32'hB4, 0, 12'd0, 1);
        cyc();
        flit("p5.b4", 3'b010, 32'hB4);
        beat(1, 32'hB5, 1, 12'd0, 1);
        cyc();
        flit("p5.t", 3'b100, 32'hB5);
        beat(0, 32'h0, 0, 12'd0, 1);
        cyc();
        idle("p5.end");
        chk("p5.err", {31'd0, len_err}, 32'd0);

        // back-to-back packets: length 2 then length 1
        beat(1, 32'hC1, 0, 12'd2, 1);
        #1 chk("b2b.rdy1", {31'd0, s_ready}, 32'd1);
        cyc();
        flit("b2b.h1", 3'b001, 32'hC1);
        beat(1, 32'hC2, 1, 12'd0, 1);
        #1 chk("b2b.rdy2", {31'd0, s_ready}, 32'd1);
        cyc();
        flit("b2b.t1", 3'b100, 32'hC2);
        beat(1, 32'hC3, 1, 12'd1, 1);
        #1 chk("b2b.rdy3", {31'd0, s_ready}, 32'd1);
        cyc();
        flit("b2b.h2", 3'b001, 32'hC3);
        chk("b2b.len2", {20'd0, length}, 32'd1);
        beat(0, 32'h0, 0, 12'd0, 1);
        cyc();
        idle("b2b.end");
        chk("b2b.err", {31'd0, len_err}, 32'd0);

        // length 4 announced, s_last on the 3rd beat
        beat(1, 32'hD1, 0, 12'd4, 1);
        cyc();
        flit("lc.h", 3'b001, 32'hD1);
        chk("lc.err_h", {31'd0, len_err}, 32'd0);
        beat(1, 32'hD2, 0, 12'd0, 1);
        cyc();
        flit("lc.b", 3'b010, 32'hD2);
        chk("lc.err_b", {31'd0, len_err}, 32'd0);
        beat(1, 32'hD3, 1, 12'd0, 1);
        cyc();
        flit("lc.t", 3'b100, 32'hD3);
        chk("lc.err_t", {31'd0, len_err}, {31'd0, LEN_CHK});
        beat(0, 32'h0, 0, 12'd0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("lc.err_hold", {31'd0, len_err}, {31'd0, LEN_CHK});
        end
        idle("lc.end");

        // reset pulsed mid-body
        beat(1, 32'hE1, 0, 12'd4, 1);
        cyc();
        beat(1, 32'hE2, 0, 12'd0, 1);
        cyc();
        flit("mr.b", 3'b010, 32'hE2);
        beat(0, 32'h0, 0, 12'd0, 1);
        #2 rst = 1'b0;
        #1;
        chk("mr.req", {31'd0, req}, 32'd0);
        chk("mr.id", {29'd0, flit_id}, 32'd0);
        chk("mr.len", {20'd0, length}, 32'd0);
        chk("mr.data", flit_data, 32'd0);
        chk("mr.err", {31'd0, len_err}, 32'd0);
        chk("mr.rdy", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("mr.rdy_rel", {31'd0, s_ready}, 32'd1);
        beat(1, 32'hF1, 0, 12'd2, 1);
        cyc();
        flit("mr.h", 3'b001, 32'hF1);
        chk("mr.len_new", {20'd0, length}, 32'd2);
        beat(1, 32'hF2, 1, 12'd0, 1);
        cyc();
        flit("mr.t", 3'b100, 32'hF2);
        beat(0, 32'h0, 0, 12'd0, 1);
        cyc();
        idle("mr.end");
        chk("mr.err_end", {31'd0, len_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
